mem_access_unit: RTL and testbench

//  MEM-stage data-memory access engine, directly downstream of the EX/MEM pipeline register.

---
 rtl/mem_access_unit.sv | 207 ++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access engine: aligns stores/loads onto a req/ack bus,
// sign-extends load data, stalls the pipeline and flags misalign/timeout.
// Ports:
//   Clk, Rst_n                      clock, async active-low reset
//   ALUResultIN, readData2IN        byte address, store data
//   MemReadIN, MemWriteIN           size codes (00 none, 01 W, 10 H, 11 B)
//   StallOUT                        hold upstream pipeline registers
//   MemReq/We/Addr/Wdata/Be         bus request outputs
//   MemAck, MemRdata                bus completion and read data
//   ReadDataOUT, ReadValidOUT       load result and its valid pulse
//   MisalignOUT, BusErrorOUT        error pulses
module mem_access_unit #(
   parameter int unsigned ACK_TIMEOUT = 255
) (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic [31:0] ALUResultIN,
   input  logic [31:0] readData2IN,
   input  logic [1:0]  MemReadIN,
   input  logic [1:0]  MemWriteIN,
   output logic        StallOUT,
   output logic        MemReq,
   output logic        MemWe,
   output logic [31:0] MemAddr,
   output logic [31:0] MemWdata,
   output logic [3:0]  MemBe,
   input  logic        MemAck,
   input  logic [31:0] MemRdata,
   output logic [31:0] ReadDataOUT,
   output logic        ReadValidOUT,
   output logic        MisalignOUT,
   output logic        BusErrorOUT
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_e;

   localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

   state_e      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic        we_q, we_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] wdata_q, wdata_d;
   logic [1:0]  size_q, size_d;
   logic [1:0]  off_q, off_d;
   logic [31:0] rdata_q, rdata_d;
   logic        rvalid_q, rvalid_d;
   logic        mis_q, mis_d;
   logic        berr_q, berr_d;

   logic        is_st;
   logic        op_vld;
   logic [1:0]  size_in;
   logic [1:0]  off_in;
   logic        misal;
   logic [3:0]  be_in;
   logic [31:0] wd_in;
   logic [7:0]  ld_b;
   logic [15:0] ld_h;
   logic [31:0] ld_ext;

   // Store wins when both size codes are nonzero.
   assign is_st   = |MemWriteIN;
   assign op_vld  = is_st | (|MemReadIN);
   assign size_in = is_st ? MemWriteIN : MemReadIN;
   assign off_in  = ALUResultIN[1:0];

   always_comb begin
      misal = 1'b0;
      be_in = 4'b1111;
      wd_in = readData2IN;
      unique case (size_in)
         2'b01: begin
            misal = |off_in;
         end
         2'b10: begin
            misal = off_in[0];
            be_in = off_in[1] ? 4'b1100 : 4'b0011;
            wd_in = {2{readData2IN[15:0]}};
         end
         2'b11: begin
            be_in = 4'b0001 << off_in;
            wd_in = {4{readData2IN[7:0]}};
         end
         default: begin
            misal = 1'b0;
         end
      endcase
   end

   // Lane select uses the offset latched at request time.
   always_comb begin
      ld_b = MemRdata[8*off_q +: 8];
      ld_h = off_q[1] ? MemRdata[31:16] : MemRdata[15:0];
      unique case (size_q)
         2'b10:   ld_ext = {{16{ld_h[15]}}, ld_h};
         2'b11:   ld_ext = {{24{ld_b[7]}}, ld_b};
         default: ld_ext = MemRdata;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      we_d     = we_q;
      be_d     = be_q;
      wdata_d  = wdata_q;
      size_d   = size_q;
      off_d    = off_q;
      rdata_d  = rdata_q;
      rvalid_d = 1'b0;
      mis_d    = 1'b0;
      berr_d   = 1'b0;
      StallOUT = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (op_vld) begin
               if (misal) begin
                  mis_d = 1'b1;
               end else begin
                  StallOUT = 1'b1;
                  addr_d   = {ALUResultIN[31:2], 2'b00};
                  we_d     = is_st;
                  be_d     = be_in;
                  wdata_d  = is_st ? wd_in : 32'd0;
                  size_d   = size_in;
                  off_d    = off_in;
                  cnt_d    = 8'd0;
                  state_d  = S_BUSY;
               end
            end
         end
         S_BUSY: begin
            StallOUT = 1'b1;
            if (MemAck) begin
               state_d = S_DONE;
               if (!we_q) begin
                  rdata_d  = ld_ext;
                  rvalid_d = 1'b1;
               end
            end else if (cnt_q == TO_LAST) begin
               state_d = S_DONE;
               berr_d  = 1'b1;
               rdata_d = 32'd0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_DONE: begin
            // Inputs still show the finished op; it must not restart.
            cnt_d   = 8'd0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= 8'd0;
         addr_q   <= 32'd0;
         we_q     <= 1'b0;
         be_q     <= 4'd0;
         wdata_q  <= 32'd0;
         size_q   <= 2'd0;
         off_q    <= 2'd0;
         rdata_q  <= 32'd0;
         rvalid_q <= 1'b0;
         mis_q    <= 1'b0;
         berr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         we_q     <= we_d;
         be_q     <= be_d;
         wdata_q  <= wdata_d;
         size_q   <= size_d;
         off_q    <= off_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
         mis_q    <= mis_d;
         berr_q   <= berr_d;
      end
   end

   // Bus outputs are quiet outside BUSY so reset drops them at once.
   assign MemReq       = (state_q == S_BUSY);
   assign MemWe        = MemReq & we_q;
   assign MemAddr      = MemReq ? addr_q : 32'd0;
   assign MemWdata     = MemReq ? wdata_q : 32'd0;
   assign MemBe        = MemReq ? be_q : 4'd0;
   assign ReadDataOUT  = rdata_q;
   assign ReadValidOUT = rvalid_q;
   assign MisalignOUT  = mis_q;
   assign BusErrorOUT  = berr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed ops, expected bus
// requests and result pulses are queued and checked by a monitor.
module tb_mem_access_unit;

   typedef enum int {EV_REQ, EV_RD, EV_MIS, EV_BERR} ev_e;
   typedef struct {
      ev_e         kind;
      logic [31:0] addr;
      logic [3:0]  be;
      logic        we;
      logic [31:0] wdata;
      logic [31:0] data;
   } ev_t;

   logic        Clk = 1'b0;
   logic        Rst_n;
   logic [31:0] ALUResultIN;
   logic [31:0] readData2IN;
   logic [1:0]  MemReadIN;
   logic [1:0]  MemWriteIN;
   logic        StallOUT;
   logic        MemReq;
   logic        MemWe;
   logic [31:0] MemAddr;
   logic [31:0] MemWdata;
   logic [3:0]  MemBe;
   logic        MemAck;
   logic [31:0] MemRdata;
   logic [31:0] ReadDataOUT;
   logic        ReadValidOUT;
   logic        MisalignOUT;
   logic        BusErrorOUT;

   int   errors = 0;
   int   checks = 0;
   ev_t  exp_q[$];
   int   ack_dly = -1;
   int   busy_n  = 0;
   logic req_prev = 1'b0;

   mem_access_unit #(.ACK_TIMEOUT(255)) dut (
      .Clk(Clk), .Rst_n(Rst_n),
      .ALUResultIN(ALUResultIN), .readData2IN(readData2IN),
      .MemReadIN(MemReadIN), .MemWriteIN(MemWriteIN),
      .StallOUT(StallOUT), .MemReq(MemReq), .MemWe(MemWe),
      .MemAddr(MemAddr), .MemWdata(MemWdata), .MemBe(MemBe),
      .MemAck(MemAck), .MemRdata(MemRdata),
      .ReadDataOUT(ReadDataOUT), .ReadValidOUT(ReadValidOUT),
      .MisalignOUT(MisalignOUT), .BusErrorOUT(BusErrorOUT)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h", nm, got, exp);
      end
   endtask

   task automatic push_req(input logic [31:0] a, input logic [3:0] be,
                           input logic we, input logic [31:0] wd);
      ev_t e;
      e = '{kind: EV_REQ, addr: a, be: be, we: we, wdata: wd, data: 0};
      exp_q.push_back(e);
   endtask

   task automatic push_ev(input ev_e k, input logic [31:0] d);
      ev_t e;
      e = '{kind: k, addr: 0, be: 0, we: 0, wdata: 0, data: d};
      exp_q.push_back(e);
   endtask

   task automatic take(input ev_e k, output ev_t e, output bit ok);
      checks++;
      ok = 1'b0;
      e  = '{kind: EV_REQ, addr: 0, be: 0, we: 0, wdata: 0, data: 0};
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event got=%0d want=none", k);
      end else if (exp_q[0].kind != k) begin
         errors++;
         $display("FAIL event_kind got=%0d want=%0d", k, exp_q[0].kind);
         void'(exp_q.pop_front());
      end else begin
         e  = exp_q.pop_front();
         ok = 1'b1;
      end
   endtask

   // Bus responder: ack after ack_dly wait cycles (negative = never).
   always @(negedge Clk) begin
      if (MemReq) begin
         MemAck = (busy_n == ack_dly);
         busy_n = busy_n + 1;
      end else begin
         MemAck = 1'b0;
         busy_n = 0;
      end
   end

   // Monitor: pops the scoreboard whenever the DUT presents an event.
   always @(negedge Clk) begin
      ev_t e;
      bit  ok;
      if (!Rst_n) begin
         req_prev = 1'b0;
      end else begin
         if (MemReq && !req_prev) begin
            take(EV_REQ, e, ok);
            if (ok) begin
               chk("req_addr", MemAddr, e.addr);
               chk("req_be", {28'd0, MemBe}, {28'd0, e.be});
               chk("req_we", {31'd0, MemWe}, {31'd0, e.we});
               if (e.we) chk("req_wdata", MemWdata, e.wdata);
            end
         end
         req_prev = MemReq;
         if (ReadValidOUT) begin
            take(EV_RD, e, ok);
            if (ok) chk("rd_data", ReadDataOUT, e.data);
         end
         if (MisalignOUT) take(EV_MIS, e, ok);
         if (BusErrorOUT) take(EV_BERR, e, ok);
      end
   end

   // Pipeline model: holds the op while StallOUT is high.
   task automatic issue(input logic [1:0] rd, input logic [1:0] wr,
                        input logic [31:0] a, input logic [31:0] d,
                        input int dly, input logic [31:0] rdat,
                        input int exp_stall, input string nm);
      int n;
      n = 0;
      @(posedge Clk);
      #1;
      ack_dly     = dly;
      MemRdata    = rdat;
      MemReadIN   = rd;
      MemWriteIN  = wr;
      ALUResultIN = a;
      readData2IN = d;
      for (int i = 0; i < 1000; i++) begin
         @(negedge Clk);
         if (!StallOUT) break;
         n++;
      end
      chk({nm, "_stalls"}, n, exp_stall);
      @(posedge Clk);
      #1;
      MemReadIN  = 2'b00;
      MemWriteIN = 2'b00;
   endtask

   initial begin
      Rst_n       = 1'b0;
      ALUResultIN = 0;
      readData2IN = 0;
      MemReadIN   = 0;
      MemWriteIN  = 0;
      MemAck      = 0;
      MemRdata    = 0;
      #12;
      chk("rst_stall", {31'd0, StallOUT}, 0);
      chk("rst_req", {31'd0, MemReq}, 0);
      chk("rst_rdata", ReadDataOUT, 0);
      chk("rst_flags", {29'd0, ReadValidOUT, MisalignOUT, BusErrorOUT}, 0);
      @(negedge Clk);
      Rst_n = 1'b1;

      push_req(32'h100, 4'b1111, 1'b1, 32'hDEADBEEF);
      issue(2'b00, 2'b01, 32'h100, 32'hDEADBEEF, 0, 0, 2, "sw");

      push_req(32'h200, 4'b1000, 1'b0, 0);
      push_ev(EV_RD, 32'hFFFFFF80);
      issue(2'b11, 2'b00, 32'h203, 0, 3, 32'h80000000, 5, "lb");

      push_ev(EV_MIS, 0);
      issue(2'b10, 2'b00, 32'h101, 0, 0, 0, 0, "lh_mis");
      push_ev(EV_MIS, 0);
      issue(2'b01, 2'b00, 32'h102, 0, 0, 0, 0, "lw_mis");

      push_req(32'h40, 4'b0010, 1'b1, 32'hABABABAB);
      push_ev(EV_BERR, 0);
      issue(2'b00, 2'b11, 32'h41, 32'h123456AB, -1, 0, 256, "sb_to");

      push_req(32'h8, 4'b1111, 1'b1, 32'h0BADF00D);
      issue(2'b01, 2'b01, 32'h8, 32'h0BADF00D, 0, 32'hFFFFFFFF, 2, "both");

      push_req(32'h10, 4'b1111, 1'b0, 0);
      push_ev(EV_RD, 32'h12345678);
      issue(2'b01, 2'b00, 32'h10, 0, 1, 32'h12345678, 3, "lw");

      push_req(32'h0, 4'b0011, 1'b0, 0);
      push_ev(EV_RD, 32'hFFFF8001);
      issue(2'b10, 2'b00, 32'h0, 0, 0, 32'h55558001, 2, "lh_neg");

      push_req(32'h0, 4'b0010, 1'b0, 0);
      push_ev(EV_RD, 32'h0000007F);
      issue(2'b11, 2'b00, 32'h1, 0, 0, 32'h00007F00, 2, "lb_pos");

      push_req(32'h4, 4'b1100, 1'b1, 32'hBEEFBEEF);
      issue(2'b00, 2'b10, 32'h6, 32'hAAAABEEF, 2, 0, 4, "sh");

      // Reset while a load is outstanding.
      push_req(32'h20, 4'b1111, 1'b0, 0);
      @(posedge Clk);
      #1;
      ack_dly     = -1;
      ALUResultIN = 32'h20;
      MemReadIN   = 2'b01;
      repeat (3) @(negedge Clk);
      chk("busy_req", {31'd0, MemReq}, 1);
      #1;
      Rst_n     = 1'b0;
      MemReadIN = 2'b00;
      #1;
      chk("rst_busy_req", {31'd0, MemReq}, 0);
      chk("rst_busy_stall", {31'd0, StallOUT}, 0);
      repeat (2) @(negedge Clk);
      Rst_n = 1'b1;

      push_req(32'h0, 4'b1100, 1'b0, 0);
      push_ev(EV_RD, 32'h00007FFF);
      issue(2'b10, 2'b00, 32'h2, 0, 0, 32'h7FFF0000, 2, "lh_post");

      repeat (5) @(posedge Clk);
      chk("sb_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
